dma_write: RTL and testbench
============================

DMA_WRITE -- requirements
Module: dma_write

Interface
REQ-001 SHALL have parameter WR_INDEX, default 10000: DMA destination index issued on the write control channel.
REQ-002 SHALL have parameter WR_LEN, default 128: number of 64-bit beats per transfer; legal range 0..32767.
REQ-003 SHALL have parameter SRAM_BASE, default 0: first 32-bit activation SRAM word read.
REQ-004 SHALL have port clk  input  1: single clock, rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port do_write  input  1: start request, level-sampled in IDLE.
REQ-007 SHALL have port write_done  output  1: one-cycle completion pulse.
REQ-008 SHALL have port dma_write_ctrl_valid  output  1: control request valid.
REQ-009 SHALL have port dma_write_ctrl_ready  input  1: control request accepted.
REQ-010 SHALL have port dma_write_ctrl_data_index  output  32: destination index.
REQ-011 SHALL have port dma_write_ctrl_data_length  output  32: beat count.
REQ-012 SHALL have port dma_write_ctrl_data_size  output  3: transfer size code.
REQ-013 SHALL have port dma_write_chnl_valid  output  1: data beat valid.
REQ-014 SHALL have port dma_write_chnl_ready  input  1: data beat accepted.
REQ-015 SHALL have port dma_write_chnl_data  output  64: data beat.
REQ-016 SHALL have port sram_addr0  output  16: SRAM port-0 read address (even word).
REQ-017 SHALL have port sram_addr1  output  16: SRAM port-1 read address (odd word).
REQ-018 SHALL have port sram_rdata0  input  32: port-0 read data, one-cycle latency.
REQ-019 SHALL have port sram_rdata1  input  32: port-1 read data, one-cycle latency.

Function
REQ-020 SHALL implement states IDLE, CTRL, ADDR, LOAD, SEND, DONE, all transitions on rising clk.
REQ-021 IDLE: when do_write=1, SHALL go to CTRL; beat counter cleared to 0.
REQ-022 CTRL: SHALL drive ctrl_valid=1, index=WR_INDEX, length=WR_LEN, size=3'b010, all held stable until ctrl_ready=1 is sampled.
REQ-023 On the ctrl handshake (valid & ready), SHALL go to ADDR, or to DONE if WR_LEN=0; ctrl_valid SHALL be 0 the following cycle.
REQ-024 sram_addr0 SHALL equal SRAM_BASE+2*beat and sram_addr1 SHALL equal SRAM_BASE+2*beat+1 (16-bit, wrap modulo 2^16) whenever state is ADDR or LOAD.
REQ-025 ADDR: SHALL last exactly one cycle, then go to LOAD.
REQ-026 LOAD: SHALL register chnl_data={sram_rdata1, sram_rdata0} and go to SEND, with chnl_valid=1 from the next cycle.
REQ-027 SEND: chnl_valid and chnl_data SHALL stay constant until chnl_ready=1 is sampled; no beat is dropped or duplicated.
REQ-028 On the chnl handshake, SHALL increment beat; if beat was WR_LEN-1 go to DONE, else go to ADDR with chnl_valid=0 next cycle.
REQ-029 Throughput with chnl_ready tied high SHALL be exactly 3 cycles per beat.
REQ-030 DONE: write_done SHALL be 1 for exactly one cycle, then state returns to IDLE.
REQ-031 do_write SHALL be ignored outside IDLE; a do_write held high through DONE SHALL start a new transfer from IDLE.
REQ-032 ctrl_valid and chnl_valid SHALL never be high in the same cycle.
REQ-033 Outside CTRL, ctrl index/length/size SHALL be 0; outside SEND, chnl_data SHALL retain its last value.

Reset
REQ-034 rst=0 SHALL immediately, without waiting for clk, force state IDLE, beat 0, and all outputs to 0 (valids, write_done, ctrl fields, chnl_data, sram addresses).
REQ-035 A reset during any transfer SHALL abandon that transfer; after release the block SHALL wait for a new do_write.

Verification
REQ-036 Defaults, ctrl_ready high after 3 cycles, chnl_ready tied 1, SRAM word n = n -> one ctrl request (10000,128,3'b010); 128 beats, beat k = {2k+1,2k}; write_done 3*128 cycles after the ctrl handshake.
REQ-037 Random chnl_ready backpressure (50%) -> beat data held stable while valid & !ready; exactly 128 unique beats in order.
REQ-038 WR_LEN=1, SRAM_BASE=0xFFFE -> single beat read at addresses 0xFFFE/0xFFFF; write_done follows that handshake.
REQ-039 WR_LEN=0 -> ctrl request with length 0, no chnl_valid, write_done one cycle after ctrl handshake.
REQ-040 rst asserted mid-SEND at beat 5 -> outputs 0 asynchronously; after release with do_write, transfer restarts at beat 0.

Source files
------------

// File: rtl/dma_write.sv
// -----------------------------------------------------------------------------
// dma_write
//
// Streams a block of activation SRAM out over a DMA write interface.
// A transfer starts with one control request (destination index, beat count,
// size code) and then sends WR_LEN 64-bit beats. Each beat is assembled from
// two adjacent 32-bit SRAM words read in parallel on the two SRAM ports.
// With chnl_ready tied high one beat leaves every 3 cycles (ADDR/LOAD/SEND).
//
// Parameters
//   WR_INDEX   destination index issued on the control channel
//   WR_LEN     beats per transfer (0..32767); 0 sends only the control request
//   SRAM_BASE  first 32-bit SRAM word read
//
// Ports
//   clk                        rising-edge clock
//   rst                        asynchronous active-low reset
//   do_write                   start request, sampled only while idle
//   write_done                 one-cycle completion pulse
//   dma_write_ctrl_valid/ready control request handshake
//   dma_write_ctrl_data_*      index / length / size of the request
//   dma_write_chnl_valid/ready data beat handshake
//   dma_write_chnl_data        64-bit data beat {odd word, even word}
//   sram_addr0 / sram_addr1    even / odd word read addresses
//   sram_rdata0 / sram_rdata1  read data, one cycle after the address
// -----------------------------------------------------------------------------
module dma_write #(
  parameter int unsigned WR_INDEX  = 32'd10000,
  parameter int unsigned WR_LEN    = 32'd128,
  parameter int unsigned SRAM_BASE = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        do_write,
  output logic        write_done,
  output logic        dma_write_ctrl_valid,
  input  logic        dma_write_ctrl_ready,
  output logic [31:0] dma_write_ctrl_data_index,
  output logic [31:0] dma_write_ctrl_data_length,
  output logic [2:0]  dma_write_ctrl_data_size,
  output logic        dma_write_chnl_valid,
  input  logic        dma_write_chnl_ready,
  output logic [63:0] dma_write_chnl_data,
  output logic [15:0] sram_addr0,
  output logic [15:0] sram_addr1,
  input  logic [31:0] sram_rdata0,
  input  logic [31:0] sram_rdata1
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CTRL = 3'd1,
    S_ADDR = 3'd2,
    S_LOAD = 3'd3,
    S_SEND = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [31:0] INDEX_W   = WR_INDEX;
  localparam logic [31:0] LEN_W     = WR_LEN;
  localparam logic [31:0] BASE_W    = SRAM_BASE;
  localparam logic [15:0] BASE16    = BASE_W[15:0];
  // Only meaningful for WR_LEN >= 1; a zero-length transfer never reaches SEND.
  localparam logic [15:0] LAST_BEAT = LEN_W[15:0] - 16'd1;
  localparam logic        LEN_ZERO  = (LEN_W == 32'd0);
  localparam logic [2:0]  SIZE_64   = 3'b010;

  state_e      state_q, state_d;
  logic [15:0] beat_q, beat_d;
  logic [63:0] data_q, data_d;
  logic [15:0] rd_addr_s;

  // Even-word address of the current beat; 16-bit add wraps modulo 2^16.
  assign rd_addr_s = BASE16 + {beat_q[14:0], 1'b0};

  // State, beat counter and beat data registers; reset is asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      beat_q  <= 16'd0;
      data_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
    end
  end

  // Next-state, beat counter and data-capture logic.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        beat_d = 16'd0;
        if (do_write) begin
          state_d = S_CTRL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CTRL: begin
        if (dma_write_ctrl_ready) begin
          state_d = LEN_ZERO ? S_DONE : S_ADDR;
        end else begin
          state_d = S_CTRL;
        end
      end
      S_ADDR: begin
        // Address is presented this cycle; SRAM data arrives during LOAD.
        state_d = S_LOAD;
      end
      S_LOAD: begin
        data_d  = {sram_rdata1, sram_rdata0};
        state_d = S_SEND;
      end
      S_SEND: begin
        if (dma_write_chnl_ready) begin
          beat_d  = beat_q + 16'd1;
          state_d = (beat_q == LAST_BEAT) ? S_DONE : S_ADDR;
        end else begin
          state_d = S_SEND;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = 16'd0;
      end
    endcase
  end

  // Output decode; every output is a pure function of registered state, so
  // the asynchronous reset clears them immediately.
  always_comb begin
    write_done                 = 1'b0;
    dma_write_ctrl_valid       = 1'b0;
    dma_write_ctrl_data_index  = 32'd0;
    dma_write_ctrl_data_length = 32'd0;
    dma_write_ctrl_data_size   = 3'd0;
    dma_write_chnl_valid       = 1'b0;
    sram_addr0                 = 16'd0;
    sram_addr1                 = 16'd0;
    case (state_q)
      S_CTRL: begin
        dma_write_ctrl_valid       = 1'b1;
        dma_write_ctrl_data_index  = INDEX_W;
        dma_write_ctrl_data_length = LEN_W;
        dma_write_ctrl_data_size   = SIZE_64;
      end
      S_ADDR, S_LOAD: begin
        // Held through LOAD so the SRAM output stays on the same words.
        sram_addr0 = rd_addr_s;
        sram_addr1 = rd_addr_s + 16'd1;
      end
      S_SEND: begin
        dma_write_chnl_valid = 1'b1;
      end
      S_DONE: begin
        write_done = 1'b1;
      end
      default: begin
        write_done = 1'b0;
      end
    endcase
  end

  // Beat data register drives the channel directly and holds between beats.
  assign dma_write_chnl_data = data_q;

endmodule

// File: tb/tb_dma_write.sv
module tb_dma_write;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  // Instance d: default parameters
  logic        d_do_write, d_write_done, d_ctrl_valid, d_ctrl_ready;
  logic [31:0] d_ctrl_index, d_ctrl_len;
  logic [2:0]  d_ctrl_size;
  logic        d_chnl_valid, d_chnl_ready;
  logic [63:0] d_chnl_data;
  logic [15:0] d_addr0, d_addr1;
  logic [31:0] d_rdata0, d_rdata1;

  // Instance o: one beat at the top of the address space
  logic        o_do_write, o_write_done, o_ctrl_valid, o_ctrl_ready;
  logic [31:0] o_ctrl_index, o_ctrl_len;
  logic [2:0]  o_ctrl_size;
  logic        o_chnl_valid, o_chnl_ready;
  logic [63:0] o_chnl_data;
  logic [15:0] o_addr0, o_addr1;
  logic [31:0] o_rdata0, o_rdata1;

  // Instance z: zero-length transfer
  logic        z_do_write, z_write_done, z_ctrl_valid, z_ctrl_ready;
  logic [31:0] z_ctrl_index, z_ctrl_len;
  logic [2:0]  z_ctrl_size;
  logic        z_chnl_valid, z_chnl_ready;
  logic [63:0] z_chnl_data;
  logic [15:0] z_addr0, z_addr1;
  logic [31:0] z_rdata0, z_rdata1;
  bit          z_chnl_seen;

  dma_write u_def (
    .clk(clk), .rst(rst), .do_write(d_do_write), .write_done(d_write_done),
    .dma_write_ctrl_valid(d_ctrl_valid), .dma_write_ctrl_ready(d_ctrl_ready),
    .dma_write_ctrl_data_index(d_ctrl_index), .dma_write_ctrl_data_length(d_ctrl_len),
    .dma_write_ctrl_data_size(d_ctrl_size),
    .dma_write_chnl_valid(d_chnl_valid), .dma_write_chnl_ready(d_chnl_ready),
    .dma_write_chnl_data(d_chnl_data),
    .sram_addr0(d_addr0), .sram_addr1(d_addr1),
    .sram_rdata0(d_rdata0), .sram_rdata1(d_rdata1)
  );

  dma_write #(.WR_LEN(32'd1), .SRAM_BASE(32'hFFFE)) u_one (
    .clk(clk), .rst(rst), .do_write(o_do_write), .write_done(o_write_done),
    .dma_write_ctrl_valid(o_ctrl_valid), .dma_write_ctrl_ready(o_ctrl_ready),
    .dma_write_ctrl_data_index(o_ctrl_index), .dma_write_ctrl_data_length(o_ctrl_len),
    .dma_write_ctrl_data_size(o_ctrl_size),
    .dma_write_chnl_valid(o_chnl_valid), .dma_write_chnl_ready(o_chnl_ready),
    .dma_write_chnl_data(o_chnl_data),
    .sram_addr0(o_addr0), .sram_addr1(o_addr1),
    .sram_rdata0(o_rdata0), .sram_rdata1(o_rdata1)
  );

  dma_write #(.WR_LEN(32'd0)) u_zero (
    .clk(clk), .rst(rst), .do_write(z_do_write), .write_done(z_write_done),
    .dma_write_ctrl_valid(z_ctrl_valid), .dma_write_ctrl_ready(z_ctrl_ready),
    .dma_write_ctrl_data_index(z_ctrl_index), .dma_write_ctrl_data_length(z_ctrl_len),
    .dma_write_ctrl_data_size(z_ctrl_size),
    .dma_write_chnl_valid(z_chnl_valid), .dma_write_chnl_ready(z_chnl_ready),
    .dma_write_chnl_data(z_chnl_data),
    .sram_addr0(z_addr0), .sram_addr1(z_addr1),
    .sram_rdata0(z_rdata0), .sram_rdata1(z_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: word n holds value n, one-cycle read latency.
  always @(posedge clk) begin
    d_rdata0 <= {16'h0000, d_addr0};
    d_rdata1 <= {16'h0000, d_addr1};
    o_rdata0 <= {16'h0000, o_addr0};
    o_rdata1 <= {16'h0000, o_addr1};
    z_rdata0 <= {16'h0000, z_addr0};
    z_rdata1 <= {16'h0000, z_addr1};
  end

  // The zero-length instance must never present a data beat.
  always @(negedge clk) begin
    if (z_chnl_valid) z_chnl_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_d_zero(input string tag);
    check_eq({tag, "_flags"}, {61'd0, d_ctrl_valid, d_chnl_valid, d_write_done}, 64'd0);
    check_eq({tag, "_data"}, d_chnl_data, 64'd0);
    check_eq({tag, "_addr"}, {32'd0, d_addr1, d_addr0}, 64'd0);
    check_eq({tag, "_ctrl"}, {d_ctrl_index, d_ctrl_len}, 64'd0);
    check_eq({tag, "_size"}, {61'd0, d_ctrl_size}, 64'd0);
  endtask

  // One transfer on the default instance. abort_at >= 0 asserts reset while
  // beat number abort_at is being offered.
  task automatic run_def(input bit bp, input int abort_at);
    int beat, edges, hs_edge, lat, ctrl_wait, viol;
    bit done_seen, ctrl_checked, hold_pending, post_ctrl;
    logic [63:0] held, exp;
    beat = 0; edges = 0; hs_edge = 0; lat = -1; ctrl_wait = 0; viol = 0;
    done_seen = 1'b0; ctrl_checked = 1'b0; hold_pending = 1'b0; post_ctrl = 1'b0;
    held = 64'd0;
    d_ctrl_ready = 1'b0;
    d_chnl_ready = 1'b0;
    d_do_write   = 1'b1;
    @(negedge clk); edges++;
    d_do_write = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
      if (d_ctrl_valid && d_chnl_valid) viol++;
      if (hold_pending && (!d_chnl_valid || d_chnl_data !== held)) viol++;
      hold_pending = 1'b0;
      if (post_ctrl) begin
        check_eq("ctrl_valid_after_hs", {63'd0, d_ctrl_valid}, 64'd0);
        check_eq("ctrl_fields_after_hs", {d_ctrl_index, d_ctrl_len}, 64'd0);
        post_ctrl = 1'b0;
      end
      if (d_ctrl_valid) begin
        if (!ctrl_checked) begin
          check_eq("ctrl_index", {32'd0, d_ctrl_index}, 64'd10000);
          check_eq("ctrl_length", {32'd0, d_ctrl_len}, 64'd128);
          check_eq("ctrl_size", {61'd0, d_ctrl_size}, 64'd2);
          ctrl_checked = 1'b1;
        end else if (d_ctrl_index !== 32'd10000 || d_ctrl_len !== 32'd128 || d_ctrl_size !== 3'b010) begin
          viol++;
        end
        d_ctrl_ready = (ctrl_wait >= 3);
        ctrl_wait++;
        if (d_ctrl_ready) begin
          hs_edge   = edges + 1;
          post_ctrl = 1'b1;
        end
      end else begin
        d_ctrl_ready = 1'b0;
      end
      if (d_chnl_valid) begin
        if (abort_at >= 0 && beat == abort_at) begin
          d_chnl_ready = 1'b0;
          #2 rst = 1'b0;
          #1 check_d_zero("async_rst");
          check_eq("abort_beat", 64'(beat), 64'd5);
          return;
        end
        d_chnl_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (d_chnl_ready) begin
          exp = {32'(2 * beat + 1), 32'(2 * beat)};
          check_eq("beat_data", d_chnl_data, exp);
          beat++;
        end else begin
          hold_pending = 1'b1;
          held         = d_chnl_data;
        end
      end else begin
        d_chnl_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (d_write_done) begin
        done_seen = 1'b1;
        lat       = edges - hs_edge;
      end
      @(negedge clk); edges++;
    end
    check_eq("done_seen", {63'd0, done_seen}, 64'd1);
    check_eq("done_one_cycle", {63'd0, d_write_done}, 64'd0);
    check_eq("idle_after_done", {62'd0, d_ctrl_valid, d_chnl_valid}, 64'd0);
    check_eq("beat_count", 64'(beat), 64'd128);
    check_eq("protocol_viol", 64'(viol), 64'd0);
    if (!bp) check_eq("done_latency", 64'(lat), 64'd384);
    d_chnl_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    z_chnl_seen = 1'b0;
    rst = 1'b0;
    d_do_write = 1'b0; d_ctrl_ready = 1'b0; d_chnl_ready = 1'b0;
    o_do_write = 1'b0; o_ctrl_ready = 1'b1; o_chnl_ready = 1'b1;
    z_do_write = 1'b0; z_ctrl_ready = 1'b1; z_chnl_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_d_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_no_start", {63'd0, d_ctrl_valid}, 64'd0);

    // Nominal transfer, then random backpressure.
    run_def(1'b0, -1);
    run_def(1'b1, -1);

    // Reset mid-transfer, then a fresh transfer from beat 0.
    run_def(1'b0, 5);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("no_resume_after_rst", {62'd0, d_ctrl_valid, d_chnl_valid}, 64'd0);
    run_def(1'b0, -1);

    // Single beat at SRAM 0xFFFE/0xFFFF.
    o_do_write = 1'b1;
    @(negedge clk); o_do_write = 1'b0;
    check_eq("one_ctrl", {31'd0, o_ctrl_valid, o_ctrl_len}, {31'd0, 1'b1, 32'd1});
    @(negedge clk);
    check_eq("one_addr_a", {32'd0, o_addr1, o_addr0}, 64'hFFFF_FFFE);
    @(negedge clk);
    check_eq("one_addr_l", {32'd0, o_addr1, o_addr0}, 64'hFFFF_FFFE);
    @(negedge clk);
    check_eq("one_valid", {62'd0, o_chnl_valid, o_write_done}, 64'd2);
    check_eq("one_data", o_chnl_data, 64'h0000FFFF_0000FFFE);
    @(negedge clk);
    check_eq("one_done", {62'd0, o_chnl_valid, o_write_done}, 64'd1);
    check_eq("one_data_held", o_chnl_data, 64'h0000FFFF_0000FFFE);
    @(negedge clk);
    check_eq("one_done_drop", {63'd0, o_write_done}, 64'd0);

    // Zero length with do_write held high through DONE.
    z_do_write = 1'b1;
    @(negedge clk);
    check_eq("zero_ctrl", {31'd0, z_ctrl_valid, z_ctrl_len}, {31'd0, 1'b1, 32'd0});
    check_eq("zero_index", {29'd0, z_ctrl_size, z_ctrl_index}, {29'd0, 3'b010, 32'd10000});
    @(negedge clk);
    check_eq("zero_done", {62'd0, z_ctrl_valid, z_write_done}, 64'd1);
    @(negedge clk);
    check_eq("zero_idle", {62'd0, z_ctrl_valid, z_write_done}, 64'd0);
    @(negedge clk);
    check_eq("zero_restart", {62'd0, z_ctrl_valid, z_write_done}, 64'd2);
    z_do_write = 1'b0;
    @(negedge clk);
    check_eq("zero_done2", {62'd0, z_ctrl_valid, z_write_done}, 64'd1);
    @(negedge clk);
    check_eq("zero_idle2", {62'd0, z_ctrl_valid, z_write_done}, 64'd0);
    check_eq("zero_no_chnl", {63'd0, z_chnl_seen}, 64'd0);
    check_eq("zero_chnl_data", z_chnl_data, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
